stream_arbiter_mux: RTL and testbench

Registered, flow-controlled successor to the plain index multiplexer. It collects `2**SELECT_WIDTH` valid/ready input channels of `WIDTH` bits onto one registered output channel. The source channel is chosen either by an external index (fixed mode) or by a round-robin arbiter. The maze generator uses it to merge candidate-cell streams from multiple neighbour/wall generators into the single carve pipeline. The block tags every output beat with its source channel.

---
 rtl/maze_stream_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/stream_arbiter_mux.sv | 110 +++++++++++
 tb/tb_stream_arbiter_mux.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/maze_stream_pkg.sv
// Shared definitions for the maze stream merging blocks: channel-count helper,
// default sizes and the source-selection mode encoding.
package maze_stream_pkg;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_SELECT_WIDTH = 2;
    localparam int DEFAULT_CHANNELS     = 1 << DEFAULT_SELECT_WIDTH;

    function automatic int channel_count(input int select_width);
        return 1 << select_width;
    endfunction

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester above last_grant_i
// (wrapping around) wins; produces a one-hot grant plus its encoded index.
module rr_arbiter
    import maze_stream_pkg::*;
#(
    parameter int N    = DEFAULT_CHANNELS,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] last_grant_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] grant_idx_o,
    output logic            grant_valid_o
);

    logic [IDXW-1:0] cand;

    // N is a power of two, so the IDXW-bit add wraps exactly modulo N;
    // offset N lands back on last_grant_i, giving it the lowest priority.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int off = 1; off <= N; off++) begin
            cand = last_grant_i + IDXW'(off);
            if (!grant_valid_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter_mux.sv
// Merges 2**SELECT_WIDTH valid/ready channels into one registered output beat,
// tagged with its source channel; source chosen by fixed index or round-robin.
module stream_arbiter_mux
    import maze_stream_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int SELECT_WIDTH = DEFAULT_SELECT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WIDTH-1:0]        in_data [2**SELECT_WIDTH],
    input  logic [2**SELECT_WIDTH-1:0] in_valid,
    output logic [2**SELECT_WIDTH-1:0] in_ready,
    input  logic                    mode_rr,
    input  logic [SELECT_WIDTH-1:0] index,
    output logic [WIDTH-1:0]        data_out,
    output logic [SELECT_WIDTH-1:0] out_index,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int N = channel_count(SELECT_WIDTH);

    mux_mode_e mode;
    assign mode = mode_rr ? MODE_RR : MODE_FIXED;

    logic [WIDTH-1:0]        data_q, data_d;
    logic [SELECT_WIDTH-1:0] idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic [SELECT_WIDTH-1:0] last_grant_q, last_grant_d;

    logic load_en;
    assign load_en = !valid_q || out_ready;

    logic [N-1:0]            rr_grant;
    logic [SELECT_WIDTH-1:0] rr_idx;
    logic                    rr_valid;

    rr_arbiter #(
        .N    (N),
        .IDXW (SELECT_WIDTH)
    ) u_rr_arbiter (
        .req_i         (in_valid),
        .last_grant_i  (last_grant_q),
        .grant_o       (rr_grant),
        .grant_idx_o   (rr_idx),
        .grant_valid_o (rr_valid)
    );

    logic [N-1:0]            sel_grant;
    logic [SELECT_WIDTH-1:0] sel_idx;
    logic                    sel_valid;

    // Fixed mode serves only the indexed channel, never a fallback.
    always_comb begin
        sel_grant = '0;
        sel_idx   = index;
        sel_valid = 1'b0;
        case (mode)
            MODE_RR: begin
                sel_grant = rr_grant;
                sel_idx   = rr_idx;
                sel_valid = rr_valid;
            end
            default: begin
                sel_valid = in_valid[index];
                if (in_valid[index]) begin
                    sel_grant[index] = 1'b1;
                end
            end
        endcase
    end

    assign in_ready = (reset_n && load_en) ? sel_grant : '0;

    always_comb begin
        data_d       = data_q;
        idx_d        = idx_q;
        valid_d      = valid_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            valid_d = sel_valid;
            if (sel_valid) begin
                data_d       = in_data[sel_idx];
                idx_d        = sel_idx;
                last_grant_d = sel_idx;
            end
        end
    end

    // last_grant resets to N-1 so channel 0 has first round-robin priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q       <= '0;
            idx_q        <= '0;
            valid_q      <= 1'b0;
            last_grant_q <= '1;
        end else begin
            data_q       <= data_d;
            idx_q        <= idx_d;
            valid_q      <= valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign data_out  = data_q;
    assign out_index = idx_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_arbiter_mux.sv
// Directed bench for stream_arbiter_mux with a queue-free behavioural model
// checked every negedge, plus literal expectations on key transactions.
module tb_stream_arbiter_mux;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data [N];
    logic [N-1:0] in_valid = '0;
    logic [N-1:0] in_ready;
    logic       mode_rr = 1'b0;
    logic [1:0] index = '0;
    logic [7:0] data_out;
    logic [1:0] out_index;
    logic       out_valid;
    logic       out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_arbiter_mux #(.WIDTH(8), .SELECT_WIDTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_rr   (mode_rr),
        .index     (index),
        .data_out  (data_out),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the output buffer as plain integers.
    bit model_ok = 1'b0;
    int m_valid = 0;
    int m_data  = 0;
    int m_idx   = 0;
    int m_last  = N - 1;

    function automatic int model_pick();
        if (!mode_rr) return in_valid[index] ? int'(index) : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic int model_ready();
        int g;
        g = model_pick();
        if (!reset_n) return 0;
        if (m_valid != 0 && !out_ready) return 0;
        if (g < 0) return 0;
        return 1 << g;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!reset_n) begin
            m_valid = 0; m_data = 0; m_idx = 0; m_last = N - 1;
            model_ok = 1'b1;
        end else if (m_valid == 0 || out_ready) begin
            g = model_pick();
            if (g >= 0) begin
                m_valid = 1; m_data = int'(in_data[g]); m_idx = g; m_last = g;
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_in_ready", 32'(in_ready), 32'(model_ready()));
            if (m_valid != 0) begin
                check("model_data_out", 32'(data_out), 32'(m_data));
                check("model_out_index", 32'(out_index), 32'(m_idx));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held;
        for (int i = 0; i < N; i++) in_data[i] = 8'h10 + 8'(i);

        // Reset with all channels requesting
        in_valid = 4'b1111;
        mode_rr  = 1'b1;
        tick(); tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        $display("txn reset: out_valid=%0d data_out=%0h", out_valid, data_out);

        // Round-robin fairness
        reset_n = 1'b1;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_index", 32'(out_index), 32'(k % 4));
            check("rr_data", 32'(data_out), 32'(8'h10 + 8'(k % 4)));
            $display("txn rr %0d: out_index=%0d data_out=%0h", k, out_index, data_out);
        end

        // Fixed mode on channel 2
        mode_rr = 1'b0; index = 2'd2; in_data[2] = 8'hA5;
        #1;
        check("fixed_ready", 32'(in_ready), 32'b0100);
        tick();
        check("fixed_data", 32'(data_out), 32'hA5);
        check("fixed_index", 32'(out_index), 32'd2);
        $display("txn fixed: out_index=%0d data_out=%0h", out_index, data_out);
        in_valid = 4'b1011;
        #1;
        check("fixed_none_ready", 32'(in_ready), 32'd0);
        tick();
        check("fixed_none_valid", 32'(out_valid), 32'd0);
        check("fixed_none_hold", 32'(data_out), 32'hA5);
        $display("txn fixed-idle: out_valid=%0d", out_valid);

        // Make channel 3 the last grant, then sparse round-robin over 1 and 3
        index = 2'd3; in_valid = 4'b1000;
        tick();
        check("sparse_prep", 32'(out_index), 32'd3);
        mode_rr = 1'b1; in_valid = 4'b1010;
        tick();
        check("sparse_1", 32'(out_index), 32'd1);
        tick();
        check("sparse_2", 32'(out_index), 32'd3);
        tick();
        check("sparse_3", 32'(out_index), 32'd1);
        $display("txn sparse: out_index=%0d data_out=%0h", out_index, data_out);

        // Backpressure: hold the beat for 5 cycles
        out_ready = 1'b0;
        held = data_out;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_hold", 32'(data_out), 32'(held));
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        $display("txn backpressure: data_out=%0h held", data_out);
        out_ready = 1'b1;
        #1;
        check("drain_reload_ready", 32'(in_ready), 32'b1000);
        tick();
        check("drain_reload_valid", 32'(out_valid), 32'd1);
        check("drain_reload_index", 32'(out_index), 32'd3);
        $display("txn drain+reload: out_index=%0d", out_index);

        // Mid-stream reset discards held beat and restarts round-robin at 0
        in_valid = 4'b1111;
        reset_n = 1'b0;
        tick();
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_data", 32'(data_out), 32'd0);
        reset_n = 1'b1;
        tick();
        check("restart_index", 32'(out_index), 32'd0);
        check("restart_valid", 32'(out_valid), 32'd1);
        $display("txn restart: out_index=%0d data_out=%0h", out_index, data_out);

        in_valid = '0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
